// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone classic initiator (wb_master)
// and the modules around it.
package wb_pkg;

   localparam int WB_ADDR_WIDTH = 32;
   localparam int WB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [WB_DATA_WIDTH-1:0] data;
      logic                     err;
   } wb_rsp_t;

endpackage : wb_pkg

// File: rtl/wb_master_if.sv
// Client request/response handshake plus Wishbone classic bus signals of wb_master.
// The master modport is the initiator's view; slave is the client and peripheral side.
interface wb_master_if
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int DATA_WIDTH = WB_DATA_WIDTH
);
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic                    req_we_i;
   logic [ADDR_WIDTH-1:0]   req_addr_i;
   logic [DATA_WIDTH-1:0]   req_data_i;
   logic [DATA_WIDTH/8-1:0] req_sel_i;

   logic                    rsp_valid_o;
   logic [DATA_WIDTH-1:0]   rsp_data_o;
   logic                    rsp_err_o;

   logic                    CYC_O;
   logic                    STB_O;
   logic                    WE_O;
   logic [ADDR_WIDTH-1:0]   ADR_O;
   logic [DATA_WIDTH-1:0]   DAT_O;
   logic [DATA_WIDTH/8-1:0] SEL_O;
   logic [DATA_WIDTH-1:0]   DAT_I;
   logic                    ACK_I;

   modport master (
      input  req_valid_i, req_we_i, req_addr_i, req_data_i, req_sel_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
      output CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O,
      input  DAT_I, ACK_I
   );

   modport slave (
      output req_valid_i, req_we_i, req_addr_i, req_data_i, req_sel_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
      input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O,
      output DAT_I, ACK_I
   );

endinterface : wb_master_if

// File: rtl/wb_master_timer.sv
// BUS-state watchdog for wb_master: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES-1 cycles have elapsed.
module wb_master_timer #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule : wb_master_timer

// File: rtl/wb_master.sv
// Wishbone classic single-transfer initiator: one client request becomes one CYC/STB cycle.
// Define WB_MASTER_TIMEOUT_EN to abort BUS cycles that see no ACK within TIMEOUT_CYCLES.
module wb_master
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = WB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   wb_master_if.master    wb
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("wb_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES at least 2");
   end

   state_t                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic                   cyc_q, cyc_d;
   logic                   we_q, we_d;
   logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
   logic [DATA_WIDTH-1:0]  dat_q, dat_d;
   logic [SEL_WIDTH-1:0]   sel_q, sel_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

`ifdef WB_MASTER_TIMEOUT_EN
   logic rsp_err_q, rsp_err_d;
   logic tmr_clear;
   logic tmr_en;
   logic tmr_expired;

   // Counter advances only on BUS cycles that saw no ACK.
   assign tmr_en = (state_q == BUS) && !wb.ACK_I;

   wb_master_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (tmr_clear),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );
`endif

   always_comb begin
      state_d     = state_q;
      ready_d     = ready_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_err_d   = rsp_err_q;
      tmr_clear   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (wb.req_valid_i && ready_q) begin
               ready_d = 1'b0;
               cyc_d   = 1'b1;
               we_d    = wb.req_we_i;
               adr_d   = wb.req_addr_i;
               dat_d   = wb.req_data_i;
               sel_d   = wb.req_sel_i;
               state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
               tmr_clear = 1'b1;
`endif
            end
         end

         BUS: begin
            ready_d = 1'b0;
            // ACK takes priority over a timeout expiring in the same cycle.
            if (wb.ACK_I) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = we_q ? '0 : wb.DAT_I;
               state_d     = DRAIN;
`ifdef WB_MASTER_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (tmr_expired) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               state_d     = DRAIN;
`endif
            end
         end

         DRAIN: begin
            // A slave may hold ACK after STB drops; wait it out before accepting again.
            ready_d = 1'b0;
            if (!wb.ACK_I) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            ready_d = 1'b0;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            adr_d   = '0;
            dat_d   = '0;
            sel_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef WB_MASTER_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end

   assign wb.rsp_err_o = rsp_err_q;
`else
   assign wb.rsp_err_o = 1'b0;
`endif

   assign wb.req_ready_o = ready_q;
   assign wb.rsp_valid_o = rsp_valid_q;
   assign wb.rsp_data_o  = rsp_data_q;
   assign wb.CYC_O       = cyc_q;
   assign wb.STB_O       = cyc_q;
   assign wb.WE_O        = we_q;
   assign wb.ADR_O       = adr_q;
   assign wb.DAT_O       = dat_q;
   assign wb.SEL_O       = sel_q;

endmodule : wb_master

// File: doc/wb_master.md
Name: wb_master

Overview:
- Wishbone classic single-transfer initiator. It converts a simple valid/ready request from a core-side client (CPU, DMA, debug bridge) into one CYC/STB bus cycle.
- Returns read data or write completion on a one-cycle response strobe.
- Pairs with the team's wb_slave peripheral bridge.
- Tolerates slaves that hold ACK until STB drops.

Parameters:
- ADDR_WIDTH, 32, width of the address bus.
- DATA_WIDTH, 32, width of the data bus; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, number of BUS-state cycles without ACK before abort. Used only with the optional feature. Must be at least 2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  client request valid.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  request address.
- req_data_i  in  DATA_WIDTH  write data.
- req_sel_i  in  DATA_WIDTH/8  byte lane selects.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_data_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  transfer aborted by timeout; qualified by rsp_valid_o.
- CYC_O  out  1  WB cycle.
- STB_O  out  1  WB strobe.
- WE_O  out  1  WB write enable.
- ADR_O  out  ADDR_WIDTH  WB address.
- DAT_O  out  DATA_WIDTH  WB write data.
- SEL_O  out  DATA_WIDTH/8  WB byte selects.
- DAT_I  in  DATA_WIDTH  WB read data.
- ACK_I  in  1  WB acknowledge.

Behaviour:
- Reset:
  - Clock is clk_i. Reset is asynchronous, active-low rst_ni; assertion takes effect immediately, mid-transfer included.
  - All outputs reset to 0 and state returns to IDLE. No response is issued for an interrupted transfer.
- Outputs: every output is registered; no combinational path from any input to any output.
- IDLE:
  - req_ready_o = 1.
  - Handshake on req_valid_i & req_ready_o at edge N: capture we/addr/data/sel into WE_O/ADR_O/DAT_O/SEL_O; CYC_O = STB_O = 1 from cycle N+1; req_ready_o = 0.
  - Go to BUS.
- BUS:
  - CYC_O, STB_O, WE_O, ADR_O, DAT_O and SEL_O are held stable. New requests are not accepted.
  - ACK_I sampled high at edge M causes, at M+1:
    - CYC_O = STB_O = 0.
    - rsp_valid_o = 1 for exactly one cycle.
    - rsp_data_o = DAT_I on reads, 0 on writes.
    - rsp_err_o = 0.
  - Then go to DRAIN.
- DRAIN:
  - req_ready_o stays 0 until ACK_I is sampled low.
  - Then req_ready_o = 1 on the next cycle and go to IDLE.
  - Prevents a lingering slave ACK from completing the next transfer early.
- Other rules:
  - ACK_I high while in IDLE is ignored.
  - rsp_data_o holds its value after the pulse until the next response. It is only meaningful while rsp_valid_o = 1.
  - Minimum request-to-request spacing is 3 cycles: accept, one BUS cycle, one DRAIN cycle, with ACK low immediately.
  - WE_O/ADR_O/DAT_O/SEL_O keep their last values when CYC_O = 0. The bench must not check them in that state.
- State encoding: 2-bit enum IDLE=0, BUS=1, DRAIN=2. Value 3 recovers to IDLE with all bus outputs 0.

Optional Feature:
- Macro WB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ACK_I.
  - When it reaches TIMEOUT_CYCLES-1 with ACK_I still low: CYC_O = STB_O = 0, rsp_valid_o = 1, rsp_err_o = 1, rsp_data_o = 0; go to DRAIN.
  - ACK_I in the same cycle as expiry wins: normal completion, err = 0.
- Not defined:
  - BUS waits indefinitely.
  - rsp_err_o is constant 0.
  - No counter logic is synthesised.

Decomposition:
- Package wb_pkg holds:
  - the wb_master state_t enum;
  - the default ADDR_WIDTH/DATA_WIDTH constants;
  - a response struct {data, err}.
- One natural sub-module, wb_master_timer: clear, enable and expired signals, width $clog2(TIMEOUT_CYCLES). Instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Reset: hold rst_ni = 0 with req_valid_i = 1 → all outputs 0; req_ready_o goes 1 only after release.
- Read: req addr 0x0000_0010, sel 0xF; slave ACKs after 3 cycles with DAT_I = 0xDEAD_BEEF → one rsp_valid_o pulse, rsp_data_o = 0xDEAD_BEEF, err = 0, CYC/STB low the next cycle.
- Write with sticky ACK: req we = 1, addr 0x20, data 0x1234_5678, sel 0x3; slave holds ACK 2 cycles past STB drop → bus shows those values; req_ready_o stays 0 until ACK drops; back-to-back request is not started early.
- Reset mid-BUS: assert rst_ni low while STB_O = 1 → CYC_O/STB_O drop asynchronously; no rsp_valid_o after reset release.
- Timeout (macro on, TIMEOUT_CYCLES = 8), no ACK → after 8 BUS cycles CYC/STB drop, rsp_valid_o = 1, err = 1, data = 0. Repeat with ACK on cycle 8 → err = 0.
- Macro off, slave never ACKs for 1000 cycles → STB_O held, no response, req_ready_o = 0.
